// File: rtl/dmem_pkg.sv
// Shared types, size codes and lane helpers for the data-memory responder.
// Optional feature macro used by the top level: DMEM_PERF_EN.
package dmem_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_e;

    // Access size codes as driven by the MEM stage
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Width of the wait-state counter (WAIT_CYCLES is 0..15)
    localparam int CNT_W = 4;

    // A request is rejected when its size is illegal or its address is not
    // naturally aligned for that size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a[0];
            SZ_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian byte-lane enables for a store
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated so every enabled lane sees it
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SZ_B:    d = {4{wd[7:0]}};
            SZ_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword out of a word and extend it
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sign,
                                                 input logic [1:0] a, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = sign ? {{24{b[7]}}, b} : {24'h000000, b};
            SZ_H:    r = sign ? {{16{h[15]}}, h} : {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-port bundle between the pipelined core and the responder.
interface dmem_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_ready;
    logic        mem_err;

    // Core side: issues requests, receives results and stall
    modport master (
        output mem_en, mem_we, mem_size, mem_sign, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall, mem_ready, mem_err
    );

    // Memory side: services requests
    modport slave (
        input  mem_en, mem_we, mem_size, mem_sign, mem_addr, mem_wdata,
        output mem_rdata, mem_stall, mem_ready, mem_err
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with four byte-write enables.
// A read issued in the same cycle as a write returns the old contents.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Registered read and byte-lane write on the same rising edge
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: accepts one load or
// store at a time, inserts WAIT_CYCLES wait states, stalls the pipeline and
// returns a one-cycle ready (and error) pulse.
// Optional macro DMEM_PERF_EN adds perf_rd / perf_wr / perf_stall counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]      perf_rd,
    output logic [31:0]      perf_wr,
    output logic [31:0]      perf_stall
`endif
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                ram_re;
    logic [3:0]          ram_be;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;
    logic                stall;
    logic                unused_addr;

    // Address bits above the RAM depth are deliberately ignored
    assign unused_addr = ^bus.mem_addr[31:ADDR_W+2];

    // The RAM read is launched one edge ahead of ACCESS (on the accept edge
    // or the last wait edge) so the word is already at the RAM output during
    // ACCESS and the extended result can be registered on the ACCESS edge.
    assign ram_re    = ((state_q == IDLE) && bus.mem_en) || (state_q == WAIT);
    assign ram_addr  = (state_q == IDLE) ? bus.mem_addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    assign ram_be    = ((state_q == ACCESS) && we_q) ? lane_be(size_q, addr_q[1:0]) : 4'b0000;
    assign ram_wdata = lane_wdata(size_q, wdata_q);

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .re_i    (ram_re),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // State and request registers; reset aborts any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: accept/check in IDLE, count wait states, access, respond
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_en) begin
                    if (is_misaligned(bus.mem_size, bus.mem_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = bus.mem_addr[ADDR_W+1:0];
                        wdata_d = bus.mem_wdata;
                        size_d  = bus.mem_size;
                        sign_d  = bus.mem_sign;
                        we_d    = bus.mem_we;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_extract(size_q, sign_q, addr_q[1:0], ram_rdata);
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall covers the accept cycle and is forced low while reset is held
    assign stall = rst && (((state_q == IDLE) && bus.mem_en) ||
                           (state_q == WAIT) || (state_q == ACCESS));

    assign bus.mem_stall = stall;
    assign bus.mem_ready = (state_q == RESP);
    assign bus.mem_err   = (state_q == RESP) && err_q;
    assign bus.mem_rdata = rdata_q;

`ifdef DMEM_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;

    // Completed legal loads/stores and stalled cycles, wrapping at 2**32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == RESP) && !err_q && !we_q) begin
                perf_rd_q <= perf_rd_q + 32'd1;
            end
            if ((state_q == RESP) && !err_q && we_q) begin
                perf_wr_q <= perf_wr_q + 32'd1;
            end
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_rd    = perf_rd_q;
    assign perf_wr    = perf_wr_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses 2 wait states, instance
// B uses none. Optional macro DMEM_PERF_EN enables the counter checks.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk;
    logic rst;

    dmem_responder_if ifa();
    dmem_responder_if ifb();

`ifdef DMEM_PERF_EN
    logic [31:0] pa_rd, pa_wr, pa_st;
    logic [31:0] pb_rd, pb_wr, pb_st;
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .perf_rd(pa_rd), .perf_wr(pa_wr), .perf_stall(pa_st)
    );
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb),
        .perf_rd(pb_rd), .perf_wr(pb_wr), .perf_stall(pb_st)
    );
`else
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );
`endif

    int          npass = 0;
    int          ntot  = 0;
    int          r_cyc;
    logic        r_err;
    logic [31:0] r_data;
    logic [31:0] r_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input bit sel, input logic en, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        if (!sel) begin
            ifa.mem_en = en; ifa.mem_we = we; ifa.mem_size = sz;
            ifa.mem_sign = sg; ifa.mem_addr = a; ifa.mem_wdata = wd;
        end else begin
            ifb.mem_en = en; ifb.mem_we = we; ifb.mem_size = sz;
            ifb.mem_sign = sg; ifb.mem_addr = a; ifb.mem_wdata = wd;
        end
    endtask

    // One request; cycle 0 is the accept cycle. Records ready cycle, stall
    // pattern per cycle, and err/rdata at the ready pulse.
    task automatic req(input bit sel, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        logic st, rd;
        @(negedge clk);
        drive(sel, 1'b1, we, sz, sg, a, wd);
        r_cyc  = -1;
        r_mask = '0;
        r_err  = 1'bx;
        r_data = 'x;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            st = sel ? ifb.mem_stall : ifa.mem_stall;
            rd = sel ? ifb.mem_ready : ifa.mem_ready;
            r_mask[c] = st;
            if (rd) begin
                r_cyc  = c;
                r_err  = sel ? ifb.mem_err : ifa.mem_err;
                r_data = sel ? ifb.mem_rdata : ifa.mem_rdata;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic saw_ready;
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",  {31'b0, ifa.mem_stall}, 32'd0);
        chk("rst_ready",  {31'b0, ifa.mem_ready}, 32'd0);
        chk("rst_err",    {31'b0, ifa.mem_err},   32'd0);
        chk("rst_rdata",  ifa.mem_rdata,          32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        // Word round trip
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF);
        chk("sw_cyc",   r_cyc,  32'd4);
        chk("sw_err",   {31'b0, r_err}, 32'd0);
        chk("sw_stall", r_mask, 32'h0000000F);
        req(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        chk("lw_cyc",   r_cyc,  32'd4);
        chk("lw_data",  r_data, 32'hDEADBEEF);

        // Byte and halfword lane writes
        req(1'b0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h00000080);
        chk("sb_err",   {31'b0, r_err}, 32'd0);
        req(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        chk("lw_sb",    r_data, 32'h80ADBEEF);
        req(1'b0, 1'b1, SZ_H, 1'b0, 32'h10, 32'h00001234);
        req(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        chk("lw_sh",    r_data, 32'h80AD1234);

        // Sign / zero extension
        req(1'b0, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0);
        chk("lb",       r_data, 32'hFFFFFF80);
        req(1'b0, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0);
        chk("lbu",      r_data, 32'h00000080);
        req(1'b0, 1'b0, SZ_H, 1'b1, 32'h10, 32'h0);
        chk("lh_lo",    r_data, 32'h00001234);
        req(1'b0, 1'b0, SZ_H, 1'b1, 32'h12, 32'h0);
        chk("lh_hi",    r_data, 32'hFFFF80AD);

        // Misaligned and illegal requests
        req(1'b0, 1'b0, SZ_H, 1'b1, 32'h11, 32'h0);
        chk("mis_lh_cyc",   r_cyc,  32'd1);
        chk("mis_lh_err",   {31'b0, r_err}, 32'd1);
        chk("mis_lh_rdata", r_data, 32'hFFFF80AD);
        chk("mis_lh_stall", r_mask, 32'h00000001);
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h12, 32'hCAFEF00D);
        chk("mis_sw_cyc",   r_cyc,  32'd1);
        chk("mis_sw_err",   {31'b0, r_err}, 32'd1);
        req(1'b0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
        chk("mis_sw_ram",   r_data, 32'h80AD1234);
        chk("lw_ok_err",    {31'b0, r_err}, 32'd0);
        req(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("ill_cyc",      r_cyc,  32'd1);
        chk("ill_err",      {31'b0, r_err}, 32'd1);

        // Idle with mem_en low: nothing happens
        saw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (ifa.mem_ready || ifa.mem_stall) saw_ready = 1'b1;
        end
        chk("idle_quiet", {31'b0, saw_ready}, 32'd0);

        // Reset in the middle of a store
        req(1'b0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h00000000);
        chk("pre_sw_cyc", r_cyc, 32'd4);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h20, 32'h12345678);
        @(negedge clk); #1;
        chk("mid_stall_wait", {31'b0, ifa.mem_stall}, 32'd1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
        #1;
        chk("mid_rst_stall", {31'b0, ifa.mem_stall}, 32'd0);
        chk("mid_rst_ready", {31'b0, ifa.mem_ready}, 32'd0);
        chk("mid_rst_rdata", ifa.mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (ifa.mem_ready) saw_ready = 1'b1;
        end
        chk("mid_no_ready", {31'b0, saw_ready}, 32'd0);
        req(1'b0, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
        chk("mid_lw_cyc",  r_cyc,  32'd4);
        chk("mid_lw_data", r_data, 32'h00000000);

        // Zero wait states, back to back
        req(1'b1, 1'b1, SZ_W, 1'b0, 32'h04, 32'hA5A5A5A5);
        chk("b_sw_cyc",   r_cyc,  32'd2);
        chk("b_sw_stall", r_mask, 32'h00000003);
        req(1'b1, 1'b0, SZ_W, 1'b0, 32'h04, 32'h0);
        chk("b_lw_cyc",   r_cyc,  32'd2);
        chk("b_lw_stall", r_mask, 32'h00000003);
        chk("b_lw_data",  r_data, 32'hA5A5A5A5);
`ifdef DMEM_PERF_EN
        @(negedge clk); #1;
        chk("perf_wr",    pb_wr, 32'd1);
        chk("perf_rd",    pb_rd, 32'd1);
        chk("perf_stall", pb_st, 32'd4);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
